// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: time-core strobes and button levels in, buzzer and session status out
interface alarm_ctrl_if;
  logic       i_sectick;
  logic       i_mintick;
  logic       i_match;
  logic [2:0] i_day;
  logic       i_alarmon;
  logic       i_snooze;
  logic       i_dismiss;
  logic       o_buzz;
  logic       o_active;
  logic       o_snoozed;
  logic [3:0] o_snzcnt;
  modport master (
    output i_sectick, i_mintick, i_match, i_day, i_alarmon, i_snooze, i_dismiss,
    input  o_buzz, o_active, o_snoozed, o_snzcnt
  );
  modport slave (
    input  i_sectick, i_mintick, i_match, i_day, i_alarmon, i_snooze, i_dismiss,
    output o_buzz, o_active, o_snoozed, o_snzcnt
  );
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm session FSM with weekday mask, beep pattern, limited snooze and ring timeout
module alarm_ctrl #(
  parameter int         NW          = 7,
  parameter logic [6:0] WEEKMASK    = 7'b0011111,
  parameter int         BEEP_ON     = 1,
  parameter int         BEEP_OFF    = 1,
  parameter int         SNOOZE_MIN  = 9,
  parameter int         MAX_SNOOZE  = 3,
  parameter int         TIMEOUT_MIN = 5
) (
  input logic          clk,
  input logic          rst,
  alarm_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;
  localparam logic [7:0] MASK8 = 8'(WEEKMASK);
  localparam logic [3:0] PON   = 4'(BEEP_ON);
  localparam logic [3:0] PMAX  = 4'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [3:0] SNZ   = 4'(SNOOZE_MIN);
  localparam logic [2:0] MAXS  = 3'(MAX_SNOOZE);
  localparam logic [3:0] TMO   = 4'(TIMEOUT_MIN);
  state_t     r_state, w_next;
  logic       r_match_d, r_snz_d, r_dis_d;
  logic [3:0] r_phase, w_phase, r_tmr, w_tmr, r_snzcnt, w_snz;
  logic [2:0] r_used, w_used;
  logic       r_buzz, r_active, r_snoozed;
  logic       w_match_e, w_snz_e, w_dis_e, w_day_ok;
  assign w_match_e = bus.i_match & ~r_match_d;
  assign w_snz_e   = bus.i_snooze & ~r_snz_d;
  assign w_dis_e   = bus.i_dismiss & ~r_dis_d;
  // days outside the week index the zero-padded top of the mask and never trigger
  assign w_day_ok  = (int'(bus.i_day) < NW) && MASK8[bus.i_day];
  assign bus.o_buzz    = r_buzz;
  assign bus.o_active  = r_active;
  assign bus.o_snoozed = r_snoozed;
  assign bus.o_snzcnt  = r_snzcnt;
  // next state and counters; priority is enable, dismiss, snooze, then timer events
  always_comb begin
    w_next  = r_state;
    w_phase = r_phase;
    w_tmr   = r_tmr;
    w_used  = r_used;
    w_snz   = r_snzcnt;
    case (r_state)
      IDLE: if (w_match_e && bus.i_alarmon && w_day_ok) begin
        w_next  = RING;
        w_phase = '0;
        w_tmr   = '0;
        w_used  = '0;
      end
      RING: if (!bus.i_alarmon) w_next = IDLE;
      else if (w_dis_e) w_next = DONE;
      else if (w_snz_e && r_used < MAXS) begin
        w_next = SNOOZE;
        w_snz  = SNZ;
        w_used = r_used + 3'd1;
      end else begin
        if (bus.i_sectick) w_phase = (r_phase == PMAX) ? '0 : r_phase + 4'd1;
        if (bus.i_mintick) w_tmr = r_tmr + 4'd1;
        if (bus.i_mintick && r_tmr + 4'd1 == TMO) w_next = DONE;
      end
      SNOOZE: if (!bus.i_alarmon) w_next = IDLE;
      else if (w_dis_e) w_next = DONE;
      else if (bus.i_mintick && r_snzcnt == 4'd1) begin
        w_next  = RING;
        w_phase = '0;
        w_tmr   = '0;
      end else if (bus.i_mintick) w_snz = r_snzcnt - 4'd1;
      default: if (!bus.i_alarmon || !bus.i_match) w_next = IDLE;
    endcase
  end
  // state, edge history and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_match_d <= 1'b1;
      r_snz_d   <= 1'b1;
      r_dis_d   <= 1'b1;
      r_phase   <= '0;
      r_tmr     <= '0;
      r_used    <= '0;
      r_snzcnt  <= '0;
      r_buzz    <= 1'b0;
      r_active  <= 1'b0;
      r_snoozed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_match_d <= bus.i_match;
      r_snz_d   <= bus.i_snooze;
      r_dis_d   <= bus.i_dismiss;
      r_phase   <= w_phase;
      r_tmr     <= w_tmr;
      r_used    <= w_used;
      r_snzcnt  <= (w_next == SNOOZE) ? w_snz : '0;
      r_buzz    <= (w_next == RING) && (w_phase < PON);
      r_active  <= (w_next == RING) || (w_next == SNOOZE);
      r_snoozed <= (w_next == SNOOZE);
    end
  end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed session scenarios checked through an expected-output scoreboard
module tb_alarm_ctrl;
  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_t;
  localparam logic [6:0] O  = 7'b000_0000;
  localparam logic [6:0] R1 = 7'b110_0000;
  localparam logic [6:0] R0 = 7'b010_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  q[$];
  alarm_ctrl_if bus ();
  alarm_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [6:0] z(input int n);
    return {3'b011, 4'(n)};
  endfunction
  task automatic cyc(input string tag, input logic [6:0] exp);
    sb_t        e;
    logic [6:0] got;
    q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    e   = q.pop_front();
    got = {bus.o_buzz, bus.o_active, bus.o_snoozed, bus.o_snzcnt};
    n_cmp++;
    assert (got === e.exp) else begin
      n_bad++;
      $error("FAIL %s got={buzz,act,snz,cnt}=%b exp=%b", e.tag, got, e.exp);
    end
  endtask
  task automatic sec(input string tag, input logic [6:0] exp);
    bus.i_sectick = 1'b1;
    cyc(tag, exp);
    bus.i_sectick = 1'b0;
  endtask
  task automatic mint(input string tag, input logic [6:0] exp);
    bus.i_mintick = 1'b1;
    cyc(tag, exp);
    bus.i_mintick = 1'b0;
  endtask
  task automatic snooze_round(input string tag);
    bus.i_snooze = 1'b1;
    cyc({tag, "_enter"}, z(9));
    bus.i_snooze = 1'b0;
    for (int i = 1; i < 9; i++) mint({tag, "_count"}, z(9 - i));
    mint({tag, "_wake"}, R1);
  endtask
  initial begin
    bus.i_sectick = 1'b0;
    bus.i_mintick = 1'b0;
    bus.i_match   = 1'b1;
    bus.i_day     = 3'd4;
    bus.i_alarmon = 1'b1;
    bus.i_snooze  = 1'b0;
    bus.i_dismiss = 1'b0;
    cyc("reset0", O);
    cyc("reset1", O);
    rst = 1'b0;
    cyc("match_held_thru_reset", O);
    bus.i_match = 1'b0;
    cyc("idle", O);
    bus.i_match = 1'b1;
    cyc("ring_fri", R1);
    sec("beep_off1", R0);
    sec("beep_on1", R1);
    sec("beep_off2", R0);
    sec("beep_on2", R1);
    cyc("no_tick_hold", R1);
    bus.i_dismiss = 1'b1;
    cyc("dismiss", O);
    bus.i_dismiss = 1'b0;
    cyc("done_match_high", O);
    bus.i_match = 1'b0;
    cyc("done_to_idle", O);
    bus.i_match = 1'b1;
    cyc("rering", R1);
    for (int i = 0; i < 4; i++) mint("ring_timer", R1);
    mint("timeout", O);
    cyc("timeout_hold", O);
    bus.i_match = 1'b0;
    cyc("timeout_idle", O);
    bus.i_match = 1'b1;
    cyc("rering2", R1);
    snooze_round("snz1");
    sec("after_snz1", R0);
    snooze_round("snz2");
    snooze_round("snz3");
    bus.i_snooze = 1'b1;
    cyc("snz4_ignored", R1);
    bus.i_snooze = 1'b0;
    sec("snz4_beep_off", R0);
    sec("snz4_beep_on", R1);
    bus.i_sectick = 1'b1;
    bus.i_mintick = 1'b1;
    cyc("sec_min_same", R0);
    bus.i_sectick = 1'b0;
    bus.i_mintick = 1'b0;
    bus.i_snooze  = 1'b1;
    bus.i_dismiss = 1'b1;
    cyc("dismiss_and_snooze", O);
    bus.i_snooze  = 1'b0;
    bus.i_dismiss = 1'b0;
    bus.i_match   = 1'b0;
    cyc("idle2", O);
    bus.i_match = 1'b1;
    cyc("ring3", R1);
    bus.i_snooze = 1'b1;
    cyc("snz_again", z(9));
    bus.i_snooze  = 1'b0;
    bus.i_alarmon = 1'b0;
    cyc("alarmon_off_in_snooze", O);
    bus.i_alarmon = 1'b1;
    cyc("no_edge_no_ring", O);
    bus.i_match = 1'b0;
    cyc("match_low", O);
    bus.i_alarmon = 1'b0;
    bus.i_match   = 1'b1;
    cyc("edge_while_off", O);
    bus.i_alarmon = 1'b1;
    cyc("consumed_edge", O);
    bus.i_match = 1'b0;
    bus.i_day   = 3'd5;
    cyc("set_sat", O);
    bus.i_match = 1'b1;
    cyc("sat_masked", O);
    bus.i_match = 1'b0;
    bus.i_day   = 3'd6;
    cyc("set_sun", O);
    bus.i_match = 1'b1;
    cyc("sun_masked", O);
    bus.i_match = 1'b0;
    bus.i_day   = 3'd7;
    cyc("set_day7", O);
    bus.i_match = 1'b1;
    cyc("day7_masked", O);
    bus.i_match = 1'b0;
    bus.i_day   = 3'd0;
    cyc("set_mon", O);
    bus.i_match = 1'b1;
    cyc("ring_mon", R1);
    sec("mon_beep_off", R0);
    rst = 1'b1;
    cyc("reset_mid_ring", O);
    rst = 1'b0;
    cyc("no_retrigger0", O);
    cyc("no_retrigger1", O);
    bus.i_match = 1'b0;
    cyc("post_reset_low", O);
    bus.i_match = 1'b1;
    cyc("post_reset_ring", R1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
